// File: rtl/wiener_block_sequencer.sv
// -----------------------------------------------------------------------------
// wiener_block_sequencer
//   Front-end controller for wiener_block_stats. Takes a valid/ready pixel
//   stream and feeds the stats block one sample per cycle. Samples inside a
//   block are always contiguous: a missing pixel mid-block is replaced by a
//   fill slot that repeats the previous value, and underrun_err is raised.
//   The sequencer counts variance_ready pulses so that frame_done is raised
//   only after every block's statistics have come out of the stats block.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_start           pulse, begins a frame (honoured only when idle)
//   blocks_per_frame      blocks in the frame, latched on accepted frame_start
//   pix_valid/pix_data    incoming pixel stream
//   pix_ready             high while streaming (combinational from state)
//   stats_start_of_frame  to stats block, high for the single arm cycle
//   stats_data_in         to stats block, registered sample value
//   stats_start_data      to stats block, marks sample 0 of each block
//   stats_end_of_frame    to stats block, marks the last sample of the frame
//   variance_ready        from stats block, one pulse per finished block
//   block_idx             index of the block currently being fed
//   frame_done            1-cycle pulse, all block results received
//   underrun_err          sticky, pixel gap inside a block
//   cfg_err               1-cycle pulse, frame_start with zero blocks
//   timeout_err           sticky, results did not arrive in time
// -----------------------------------------------------------------------------
module wiener_block_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [31:0]           blocks_per_frame,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  stats_start_of_frame,
  output logic [DATA_WIDTH-1:0] stats_data_in,
  output logic                  stats_start_data,
  output logic                  stats_end_of_frame,
  input  logic                  variance_ready,
  output logic [31:0]           block_idx,
  output logic                  frame_done,
  output logic                  underrun_err,
  output logic                  cfg_err,
  output logic                  timeout_err
);

  localparam int SMP_W = $clog2(TOTAL_SAMPLES);
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(TOTAL_SAMPLES - 1);
  localparam logic [SMP_W-1:0] SMP_ZERO = SMP_W'(32'd0);
  localparam logic [SMP_W-1:0] SMP_ONE  = SMP_W'(32'd1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(32'd0);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(32'd1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]            state_r;
  logic [31:0]           bpf_r;
  logic [SMP_W-1:0]      smp_cnt_r;
  logic [31:0]           block_idx_r;
  logic [31:0]           vr_cnt_r;
  logic [TMR_W-1:0]      drain_tmr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  sof_r;
  logic                  start_data_r;
  logic                  eof_r;
  logic                  frame_done_r;
  logic                  underrun_r;
  logic                  cfg_err_r;
  logic                  timeout_r;

  logic                  issue_s;
  logic                  last_smp_s;
  logic                  last_blk_s;
  logic                  vr_count_s;
  logic [31:0]           vr_next_s;
  logic                  drained_s;

  // Per-cycle decode: sample issue, block/frame boundaries, result tally.
  // A slot is issued on a real pixel, or as a fill slot when a block is
  // already open (smp_cnt != 0); gaps on block boundaries issue nothing.
  // The DRAIN check uses the tally including this cycle's variance_ready.
  always_comb begin
    issue_s    = (state_r == ST_STREAM) && (pix_valid || (smp_cnt_r != SMP_ZERO));
    last_smp_s = (smp_cnt_r == SMP_LAST);
    last_blk_s = (block_idx_r == (bpf_r - 32'd1));
    vr_count_s = variance_ready && (state_r != ST_IDLE);
    vr_next_s  = vr_cnt_r + {31'd0, vr_count_s};
    drained_s  = (vr_next_s >= bpf_r);
  end

  assign pix_ready            = (state_r == ST_STREAM);
  assign stats_start_of_frame = sof_r;
  assign stats_data_in        = data_r;
  assign stats_start_data     = start_data_r;
  assign stats_end_of_frame   = eof_r;
  assign block_idx            = block_idx_r;
  assign frame_done           = frame_done_r;
  assign underrun_err         = underrun_r;
  assign cfg_err              = cfg_err_r;
  assign timeout_err          = timeout_r;

  // Sequencer state, counters and registered stats-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bpf_r        <= 32'd0;
      smp_cnt_r    <= SMP_ZERO;
      block_idx_r  <= 32'd0;
      vr_cnt_r     <= 32'd0;
      drain_tmr_r  <= TMR_ZERO;
      data_r       <= {DATA_WIDTH{1'b0}};
      sof_r        <= 1'b0;
      start_data_r <= 1'b0;
      eof_r        <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
      cfg_err_r    <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      sof_r        <= 1'b0;
      start_data_r <= 1'b0;
      eof_r        <= 1'b0;
      frame_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      vr_cnt_r     <= vr_next_s;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            if (blocks_per_frame != 32'd0) begin
              state_r     <= ST_ARM;
              bpf_r       <= blocks_per_frame;
              smp_cnt_r   <= SMP_ZERO;
              block_idx_r <= 32'd0;
              vr_cnt_r    <= 32'd0;
              drain_tmr_r <= TMR_ZERO;
              underrun_r  <= 1'b0;
              timeout_r   <= 1'b0;
              sof_r       <= 1'b1;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          state_r <= ST_STREAM;
        end
        ST_STREAM: begin
          if (issue_s) begin
            // A fill slot keeps data_r, so the stats block sees a repeat.
            if (pix_valid) begin
              data_r <= pix_data;
            end else begin
              underrun_r <= 1'b1;
            end
            start_data_r <= (smp_cnt_r == SMP_ZERO);
            eof_r        <= last_smp_s && last_blk_s;
            if (last_smp_s) begin
              smp_cnt_r <= SMP_ZERO;
              if (last_blk_s) begin
                // block_idx stays on the final block while draining.
                state_r     <= ST_DRAIN;
                drain_tmr_r <= TMR_ZERO;
              end else begin
                block_idx_r <= block_idx_r + 32'd1;
              end
            end else begin
              smp_cnt_r <= smp_cnt_r + SMP_ONE;
            end
          end
        end
        ST_DRAIN: begin
          // Completion wins over a timeout expiring on the same cycle.
          if (drained_s) begin
            frame_done_r <= 1'b1;
            state_r      <= ST_IDLE;
          end else if (drain_tmr_r == TMR_LAST) begin
            timeout_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            drain_tmr_r <= drain_tmr_r + TMR_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wiener_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wiener_block_sequencer
//   Self-checking bench for wiener_block_sequencer. Each frame is driven cycle
//   by cycle; expectations come from a frame-level model: slot numbering
//   within the frame, the held sample value, a schedule of variance_ready
//   pulses, and closed-form frame_done / timeout cycles derived from the time
//   the frame entered draining.
// -----------------------------------------------------------------------------
module tb_wiener_block_sequencer;

  localparam int DW = 8;
  localparam int TS = 8;
  localparam int DT = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [31:0]   blocks_per_frame = 32'd0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = 8'd0;
  logic          pix_ready;
  logic          stats_start_of_frame;
  logic [DW-1:0] stats_data_in;
  logic          stats_start_data;
  logic          stats_end_of_frame;
  logic          variance_ready = 1'b0;
  logic [31:0]   block_idx;
  logic          frame_done;
  logic          underrun_err;
  logic          cfg_err;
  logic          timeout_err;

  always #5 clk = ~clk;

  wiener_block_sequencer #(
    .DATA_WIDTH(DW), .TOTAL_SAMPLES(TS), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .blocks_per_frame(blocks_per_frame), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready),
    .stats_start_of_frame(stats_start_of_frame), .stats_data_in(stats_data_in),
    .stats_start_data(stats_start_data), .stats_end_of_frame(stats_end_of_frame),
    .variance_ready(variance_ready), .block_idx(block_idx),
    .frame_done(frame_done), .underrun_err(underrun_err),
    .cfg_err(cfg_err), .timeout_err(timeout_err)
  );

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            last_sched = 0;
  int            vr_q[$];
  logic          force_vr = 1'b0;
  logic [DW-1:0] exp_data = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // End the current cycle: present any scheduled result pulse, then move to
  // 1 time unit after the next rising edge.
  task automatic tick();
    variance_ready = force_vr || (vr_q.size() > 0 && vr_q[0] == cyc);
    if (vr_q.size() > 0 && vr_q[0] == cyc) void'(vr_q.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Stats-block stand-in: each finished block yields one result a few cycles later.
  task automatic sched_vr();
    int t;
    t = cyc + int'($urandom_range(3, 20));
    if (t <= last_sched) t = last_sched + 1;
    last_sched = t;
    vr_q.push_back(t);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_sof"}, stats_start_of_frame, 0);
    chk({tag, "_data"}, stats_data_in, 0);
    chk({tag, "_sd"}, stats_start_data, 0);
    chk({tag, "_eof"}, stats_end_of_frame, 0);
    chk({tag, "_bidx"}, block_idx, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_under"}, underrun_err, 0);
    chk({tag, "_cfg"}, cfg_err, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  // mode 0: random pixels, random legal gaps and underruns, stray frame_start
  // mode 1: pixels 1,2,3.. back to back
  // mode 2: as 1 with a 3-cycle gap before block 1
  // mode 3: as 1 with one missing pixel after pixel 3
  task automatic run_frame(input int bpf, input int mode, input bit send_vr, input int abort_slot);
    int            total;
    int            slot;
    int            guard;
    int            gaps;
    int            pnum;
    int            d_cyc;
    int            exp_end;
    bit            valid;
    bit            issue;
    bit            under_exp;
    bit            exp_sd;
    bit            exp_eof;
    bit            aborted;
    logic [DW-1:0] v;
    total = bpf * TS;
    slot = 0; guard = 0; gaps = 0; pnum = 1;
    under_exp = 1'b0; aborted = 1'b0;
    last_sched = 0;
    vr_q.delete();

    frame_start = 1'b1;
    blocks_per_frame = 32'(bpf);
    tick();
    frame_start = 1'b0;
    blocks_per_frame = $urandom();
    chk("arm_sof", stats_start_of_frame, 1);
    chk("arm_ready", pix_ready, 0);
    chk("arm_under", underrun_err, 0);
    chk("arm_tmo", timeout_err, 0);
    tick();

    while (slot < total && guard < 2000) begin
      guard++;
      chk("strm_ready", pix_ready, 1);
      chk("strm_bidx", block_idx, 32'(slot / TS));
      chk("strm_cfg", cfg_err, 0);
      if (slot == abort_slot) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        exp_data = 8'd0;
        vr_q.delete();
        pix_valid = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_idle_ready", pix_ready, 0);
        chk("rst_idle_bidx", block_idx, 0);
        aborted = 1'b1;
        break;
      end
      case (mode)
        0: valid = (slot % TS == 0) ? ($urandom_range(0, 99) >= 25) : ($urandom_range(0, 99) >= 5);
        2: if (slot == TS && gaps < 3) begin valid = 1'b0; gaps++; end else valid = 1'b1;
        3: if (slot == 3 && gaps < 1) begin valid = 1'b0; gaps++; end else valid = 1'b1;
        default: valid = 1'b1;
      endcase
      v = (mode == 0) ? DW'($urandom) : DW'(pnum);
      issue = valid || (slot % TS != 0);
      pix_valid = valid;
      pix_data = v;
      if (mode == 0) frame_start = ($urandom_range(0, 9) == 0);
      exp_sd = 1'b0;
      exp_eof = 1'b0;
      if (issue) begin
        if (valid) begin
          exp_data = v;
          pnum++;
        end else begin
          under_exp = 1'b1;
        end
        exp_sd = (slot % TS == 0);
        exp_eof = (slot == total - 1);
        slot++;
        if (send_vr && slot % TS == 0) sched_vr();
      end
      tick();
      pix_valid = 1'b0;
      frame_start = 1'b0;
      chk("strm_data", stats_data_in, exp_data);
      chk("strm_sd", stats_start_data, exp_sd);
      chk("strm_eof", stats_end_of_frame, exp_eof);
      chk("strm_under", underrun_err, under_exp);
      chk("strm_sof", stats_start_of_frame, 0);
    end

    if (!aborted) begin
      chk("strm_complete", slot, total);
      d_cyc = cyc;
      // Done is visible the cycle after both draining has begun and the last
      // result has arrived; without results the timer expires DT cycles in.
      if (send_vr) exp_end = ((last_sched > d_cyc) ? last_sched : d_cyc) + 1;
      else exp_end = d_cyc + DT;
      while (cyc < exp_end) begin
        chk("drn_ready", pix_ready, 0);
        chk("drn_done", frame_done, 0);
        chk("drn_tmo", timeout_err, 0);
        chk("drn_bidx", block_idx, 32'(bpf - 1));
        chk("drn_under", underrun_err, under_exp);
        tick();
      end
      chk("end_done", frame_done, send_vr);
      chk("end_tmo", timeout_err, !send_vr);
      chk("end_ready", pix_ready, 0);
      tick();
      chk("post_done", frame_done, 0);
      chk("post_tmo", timeout_err, !send_vr);
      chk("post_ready", pix_ready, 0);
      chk("post_data", stats_data_in, exp_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("reset");

    // Zero-block frame request is rejected.
    frame_start = 1'b1;
    blocks_per_frame = 32'd0;
    tick();
    frame_start = 1'b0;
    chk("cfg_pulse", cfg_err, 1);
    chk("cfg_ready", pix_ready, 0);
    chk("cfg_sof", stats_start_of_frame, 0);
    tick();
    chk("cfg_clear", cfg_err, 0);
    chk("cfg_ready2", pix_ready, 0);

    // Results arriving while idle are not counted.
    force_vr = 1'b1;
    tick();
    tick();
    force_vr = 1'b0;
    tick();
    chk("idle_vr_done", frame_done, 0);

    run_frame(2, 1, 1'b1, -1);   // back-to-back
    run_frame(2, 2, 1'b1, -1);   // legal gap between blocks
    run_frame(2, 3, 1'b1, -1);   // underrun after pixel 3
    run_frame(1, 1, 1'b0, -1);   // no results -> timeout
    run_frame(2, 1, 1'b1, 12);   // reset at block 1 sample 4
    run_frame(2, 1, 1'b1, -1);   // normal frame after reset
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(1, 4)), 0, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
